// File: rtl/trigger_pulse_generator_if.sv
// trigger_pulse_generator_if: config, control and status bundle for trigger_pulse_generator
interface trigger_pulse_generator_if #(
    parameter int TIME_BITS  = 16,
    parameter int COUNT_BITS = 16
);
    logic [TIME_BITS-1:0]  cfg_width;
    logic [TIME_BITS-1:0]  cfg_period;
    logic [COUNT_BITS-1:0] cfg_count;
    logic                  start;
    logic                  abort;
    logic                  pulse_out;
    logic                  busy;
    logic                  done;
    logic [COUNT_BITS-1:0] pulses_sent;
    modport master (
        output cfg_width, cfg_period, cfg_count, start, abort,
        input  pulse_out, busy, done, pulses_sent
    );
    modport slave (
        input  cfg_width, cfg_period, cfg_count, start, abort,
        output pulse_out, busy, done, pulses_sent
    );
endinterface

// File: rtl/trigger_pulse_generator.sv
// trigger_pulse_generator: programmable burst/continuous trigger pulse source, all registered outputs
// Optional PULSE_GEN_EXT_START_EN adds a synchronized, edge-detected ext_start launch input.
module trigger_pulse_generator #(
    parameter int TIME_BITS  = 16,
    parameter int COUNT_BITS = 16
) (
    input logic clk_250mhz,
    input logic rst,
`ifdef PULSE_GEN_EXT_START_EN
    input logic ext_start,
`endif
    trigger_pulse_generator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t                r_state;
    logic [TIME_BITS:0]    r_w, r_p, r_t;
    logic [COUNT_BITS-1:0] r_count, r_sent;
    logic                  r_pulse, r_busy, r_done;
    logic [TIME_BITS:0]    w_w, w_p, w_t_next;
    logic                  w_start, w_end, w_last, w_high_next;
    assign w_w         = bus.cfg_width == '0 ? (TIME_BITS+1)'(1) : {1'b0, bus.cfg_width};
    assign w_p         = {1'b0, bus.cfg_period} > w_w ? {1'b0, bus.cfg_period} : w_w + 1'b1;
    assign w_t_next    = r_t + 1'b1;
    assign w_high_next = w_t_next <= r_w;
    assign w_end       = r_t == r_p;
    assign w_last      = r_count != '0 && r_sent == r_count;
`ifdef PULSE_GEN_EXT_START_EN
    logic [2:0] r_sync;
    logic       r_ext_q;
    always_ff @(posedge clk_250mhz or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_ext_q <= 1'b0;
        end else begin
            r_sync  <= {r_sync[1:0], ext_start};
            r_ext_q <= r_sync[2];
        end
    end
    assign w_start = bus.start | (r_sync[2] & ~r_ext_q);
`else
    assign w_start = bus.start;
`endif
    // r_t is the 1-based position within the current period of the cycle being driven
    always_ff @(posedge clk_250mhz or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_w     <= '0;
            r_p     <= '0;
            r_t     <= '0;
            r_count <= '0;
            r_sent  <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort) begin
                r_state <= IDLE;
                r_pulse <= 1'b0;
                r_busy  <= 1'b0;
            end else if (r_state == IDLE) begin
                if (w_start) begin
                    r_state <= HIGH;
                    r_pulse <= 1'b1;
                    r_busy  <= 1'b1;
                    r_w     <= w_w;
                    r_p     <= w_p;
                    r_count <= bus.cfg_count;
                    r_sent  <= COUNT_BITS'(1);
                    r_t     <= (TIME_BITS+1)'(1);
                end
            end else if (w_end) begin
                if (w_last) begin
                    r_state <= IDLE;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= HIGH;
                    r_pulse <= 1'b1;
                    r_t     <= (TIME_BITS+1)'(1);
                    r_sent  <= r_sent + COUNT_BITS'(r_sent != '1);
                end
            end else begin
                r_t     <= w_t_next;
                r_pulse <= w_high_next;
                r_state <= w_high_next ? HIGH : LOW;
            end
        end
    end
    assign bus.pulse_out   = r_pulse;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pulses_sent = r_sent;
endmodule

// File: tb/tb_trigger_pulse_generator.sv
// tb_trigger_pulse_generator: directed + randomized checks against a period-arithmetic reference model
module tb_trigger_pulse_generator;
    localparam int TB = 16;
    localparam int CB = 16;
    logic clk_250mhz = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_act, m_c, m_w, m_p, m_n, m_sent, m_done;
    always #2 clk_250mhz = ~clk_250mhz;
    trigger_pulse_generator_if #(.TIME_BITS(TB), .COUNT_BITS(CB)) bus ();
`ifdef PULSE_GEN_EXT_START_EN
    logic ext_start = 1'b0;
`endif
    trigger_pulse_generator #(.TIME_BITS(TB), .COUNT_BITS(CB)) dut (
        .clk_250mhz(clk_250mhz),
        .rst(rst),
`ifdef PULSE_GEN_EXT_START_EN
        .ext_start(ext_start),
`endif
        .bus(bus.slave)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask
    task automatic check_outputs();
        chk("pulse_out", 32'(bus.pulse_out), 32'(m_act != 0 && ((m_c - 1) % m_p) < m_w));
        chk("busy", 32'(bus.busy), 32'(m_act != 0));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("pulses_sent", 32'(bus.pulses_sent), 32'(m_sent));
    endtask
    // One clock: model sees the inputs that were present at the edge
    task automatic step();
        logic s, a;
        int   w, p, n, k;
        s = bus.start;
        a = bus.abort;
        w = bus.cfg_width == 0 ? 1 : int'(bus.cfg_width);
        p = int'(bus.cfg_period) > w ? int'(bus.cfg_period) : w + 1;
        n = int'(bus.cfg_count);
        @(posedge clk_250mhz);
        #1;
        m_done = 0;
        if (a) m_act = 0;
        else if (m_act != 0) begin
            m_c++;
            if (m_n != 0 && m_c > m_n * m_p) begin
                m_act  = 0;
                m_done = 1;
            end
        end else if (s) begin
            m_act = 1;
            m_c = 1;
            m_w = w;
            m_p = p;
            m_n = n;
        end
        if (m_act != 0) begin
            k = (m_c - 1) / m_p + 1;
            m_sent = k > 65535 ? 65535 : k;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_outputs();
    endtask
    task automatic run(input int k);
        repeat (k) step();
    endtask
    task automatic go(input int w, input int p, input int n);
        bus.cfg_width  = TB'(w);
        bus.cfg_period = TB'(p);
        bus.cfg_count  = CB'(n);
        bus.start      = 1'b1;
        step();
    endtask
    task automatic model_reset();
        m_act = 0; m_c = 0; m_w = 1; m_p = 2; m_n = 0; m_sent = 0; m_done = 0;
    endtask
    initial begin
        model_reset();
        rst = 1'b1;
        bus.cfg_width = '0; bus.cfg_period = '0; bus.cfg_count = '0;
        bus.start = 1'b0; bus.abort = 1'b0;
        repeat (3) @(posedge clk_250mhz);
        #1;
        check_outputs();
        rst = 1'b0;
        run(3);
        go(3, 10, 4);
        run(45);
        chk("basic_sent", 32'(bus.pulses_sent), 32'd4);
        go(0, 0, 2);
        run(8);
        go(2, 5, 0);
        run(10);
        bus.abort = 1'b1;
        step();
        chk("abort_sent", 32'(bus.pulses_sent), 32'd3);
        run(6);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        run(4);
        go(3, 10, 2);
        run(5);
        bus.start = 1'b1;
        bus.cfg_width = 16'd7;
        bus.cfg_period = 16'd3;
        step();
        run(25);
        go(4, 9, 3);
        run(12);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk_250mhz);
        #1;
        rst = 1'b0;
        run(4);
        for (int i = 0; i < 3000; i++) begin
            bus.cfg_width  = TB'($urandom_range(0, 5));
            bus.cfg_period = TB'($urandom_range(0, 12));
            bus.cfg_count  = CB'($urandom_range(0, 4));
            bus.start      = $urandom_range(0, 7) == 0;
            bus.abort      = $urandom_range(0, 39) == 0;
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
